// File: rtl/picomips_pkg.sv
// picomips_pkg: shared types and width constants for the picoMIPS datapath blocks.
`default_nettype none

package picomips_pkg;

  localparam int N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

endpackage : picomips_pkg

`default_nettype wire

// File: rtl/mult_ctrl.sv
// mult_ctrl: sequential signed multiplier (sign-magnitude shift-add) with PC stall
// handshake and Q1.7 saturated fractional result.  Rev 1.0
`default_nettype none

module mult_ctrl
  import picomips_pkg::*;
#(
  parameter int n = N
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [n-1:0]      a,
  input  logic [n-1:0]      b,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [2*n-1:0]    prod,
  output logic [n-1:0]      result
);

  localparam int CW = $clog2(n) + 1;
  localparam int PW = 2 * n;

  mult_state_t   r_state;
  mult_state_t   w_state_nxt;

  logic [CW-1:0] r_count;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_mcand;
  logic [n:0]    r_mplier;
  logic          r_sign;
  logic [PW-1:0] r_prod;
  logic [n-1:0]  r_result;

  logic [n:0]    w_ext_a;
  logic [n:0]    w_ext_b;
  logic [n:0]    w_mag_a;
  logic [n:0]    w_mag_b;
  logic [PW-1:0] w_signed_prod;
  logic          w_sat;
  logic [n-1:0]  w_result;

  // One extra magnitude bit so that -2^(n-1) survives negation.
  assign w_ext_a = {a[n-1], a};
  assign w_ext_b = {b[n-1], b};
  assign w_mag_a = w_ext_a[n] ? (~w_ext_a + (n+1)'(1)) : w_ext_a;
  assign w_mag_b = w_ext_b[n] ? (~w_ext_b + (n+1)'(1)) : w_ext_b;

  assign w_signed_prod = r_sign ? (~r_acc + PW'(1)) : r_acc;
  // Only +2^(2n-2) has top bits 01; it cannot be expressed in Q1.7.
  assign w_sat    = (w_signed_prod[PW-1 -: 2] == 2'b01);
  assign w_result = w_sat ? {1'b0, {(n-1){1'b1}}} : w_signed_prod[PW-2:n-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = RUN;
      RUN:  if (r_count == CW'(1)) w_state_nxt = FIX;
      FIX:  w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_sign   <= 1'b0;
      r_prod   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc    <= '0;
            r_mcand  <= {{(PW-n-1){1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_sign   <= a[n-1] ^ b[n-1];
            r_count  <= CW'(n);
          end
        end
        RUN: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count - CW'(1);
        end
        FIX: begin
          r_prod   <= w_signed_prod;
          r_result <= w_result;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs are forced low during reset, before the state register clears.
  assign busy   = !reset && (r_state != IDLE);
  assign done   = !reset && (r_state == DONE);
  assign stall  = !reset && (((r_state == IDLE) && start) || (r_state == RUN) || (r_state == FIX));
  assign prod   = r_prod;
  assign result = r_result;

endmodule : mult_ctrl

`default_nettype wire

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: directed self-checking bench for mult_ctrl (n = 8).
`default_nettype none

module tb_mult_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [15:0] prod;
  logic [7:0]  result;

  int n_pass;
  int n_total;

  mult_ctrl #(.n(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .prod   (prod),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 0 is the cycle in which start is presented; start is held for that cycle only.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output logic [15:0] p, output logic [7:0] r,
                        output int lat, output int stalls, output int dones);
    lat = -1; stalls = 0; dones = 0; p = 16'h0; r = 8'h0;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (stall) stalls++;
      if (done) begin
        dones++;
        if (lat < 0) begin
          lat = c; p = prod; r = result;
        end
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 8'h40; b = 8'h40;
    #1;
    n_total++;
    if ({busy, done, stall} !== 3'b000) $display("FAIL reset_outputs: busy/done/stall=%b required 000", {busy, done, stall});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({prod, result} !== 24'h0) $display("FAIL reset_regs: prod=%h result=%h required 0000 00", prod, result);
    else n_pass++;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] p; logic [7:0] r; int lat, st, dn;
    run_op(8'h40, 8'h40, p, r, lat, st, dn);
    n_total++;
    if (lat !== 10) $display("FAIL basic_latency: done at cycle %0d required 10", lat); else n_pass++;
    n_total++;
    if (st !== 10) $display("FAIL basic_stall_cycles: %0d required 10", st); else n_pass++;
    n_total++;
    if (dn !== 1) $display("FAIL basic_done_count: %0d required 1", dn); else n_pass++;
    n_total++;
    if (p !== 16'h1000 || r !== 8'h20) $display("FAIL basic_product: prod=%h result=%h required 1000 20", p, r); else n_pass++;
    n_total++;
    if (prod !== 16'h1000 || result !== 8'h20 || busy !== 1'b0)
      $display("FAIL basic_hold: prod=%h result=%h busy=%b required 1000 20 0", prod, result, busy);
    else n_pass++;
  endtask

  task automatic test_vectors();
    logic [7:0]  va [8];
    logic [7:0]  vb [8];
    logic [15:0] ep [8];
    logic [7:0]  er [8];
    logic [15:0] p; logic [7:0] r; int lat, st, dn;
    va[0] = 8'hC0; vb[0] = 8'h40; ep[0] = 16'hF000; er[0] = 8'hE0;
    va[1] = 8'h7F; vb[1] = 8'h7F; ep[1] = 16'h3F01; er[1] = 8'h7E;
    va[2] = 8'h80; vb[2] = 8'h80; ep[2] = 16'h4000; er[2] = 8'h7F;
    va[3] = 8'h80; vb[3] = 8'h7F; ep[3] = 16'hC080; er[3] = 8'h81;
    va[4] = 8'h00; vb[4] = 8'h85; ep[4] = 16'h0000; er[4] = 8'h00;
    va[5] = 8'hFF; vb[5] = 8'hFF; ep[5] = 16'h0001; er[5] = 8'h00;
    va[6] = 8'hFF; vb[6] = 8'h01; ep[6] = 16'hFFFF; er[6] = 8'hFF;
    va[7] = 8'h20; vb[7] = 8'hF0; ep[7] = 16'hFE00; er[7] = 8'hFC;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], p, r, lat, st, dn);
      n_total++;
      if (p !== ep[i] || r !== er[i])
        $display("FAIL vec%0d_product: a=%h b=%h prod=%h result=%h required %h %h", i, va[i], vb[i], p, r, ep[i], er[i]);
      else n_pass++;
      n_total++;
      if (lat !== 10 || dn !== 1)
        $display("FAIL vec%0d_timing: latency=%0d dones=%0d required 10 1", i, lat, dn);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_start();
    int dn; int lat;
    dn = 0; lat = -1;
    @(negedge clk);
    a = 8'h40; b = 8'h40; start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (done) begin dn++; if (lat < 0) lat = c; end
      @(negedge clk);
      if (c == 2) begin start = 1'b1; a = 8'h7F; b = 8'h7F; end
      else start = 1'b0;
    end
    n_total++;
    if (dn !== 1 || lat !== 10) $display("FAIL ignore_start_done: dones=%0d latency=%0d required 1 10", dn, lat); else n_pass++;
    n_total++;
    if (prod !== 16'h1000 || result !== 8'h20)
      $display("FAIL ignore_start_product: prod=%h result=%h required 1000 20", prod, result);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int dn;
    logic [15:0] p; logic [7:0] r; int lat, st;
    dn = 0;
    @(negedge clk);
    a = 8'h7F; b = 8'h7F; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++;
    if (busy !== 1'b0 || stall !== 1'b0) $display("FAIL abort_during_reset: busy=%b stall=%b required 0 0", busy, stall); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0 || stall !== 1'b0 || prod !== 16'h0 || result !== 8'h0)
      $display("FAIL abort_after: busy=%b stall=%b prod=%h result=%h required 0 0 0000 00", busy, stall, prod, result);
    else n_pass++;
    for (int c = 0; c < 15; c++) begin
      if (done) dn++;
      @(negedge clk);
      #1;
    end
    n_total++;
    if (dn !== 0) $display("FAIL abort_no_done: dones=%0d required 0", dn); else n_pass++;
    run_op(8'h20, 8'hF0, p, r, lat, st, dn);
    n_total++;
    if (p !== 16'hFE00 || r !== 8'hFC || lat !== 10)
      $display("FAIL abort_recover: prod=%h result=%h latency=%0d required FE00 FC 10", p, r, lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t [3];
    int nd;
    int bad_stall;
    nd = 0; bad_stall = 0;
    @(negedge clk);
    a = 8'h40; b = 8'h40; start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall !== !done) bad_stall++;
      if (done) begin
        if (nd < 3) t[nd] = c;
        nd++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_total++;
    if (nd !== 3) $display("FAIL b2b_count: dones=%0d required 3", nd);
    else n_pass++;
    n_total++;
    if (nd < 3 || t[0] !== 10 || t[1] !== 21 || t[2] !== 32)
      $display("FAIL b2b_spacing: done cycles %0d %0d %0d required 10 21 32", t[0], t[1], t[2]);
    else n_pass++;
    n_total++;
    if (bad_stall !== 0) $display("FAIL b2b_stall: %0d cycles with stall != !done required 0", bad_stall); else n_pass++;
    n_total++;
    if (prod !== 16'h1000 || result !== 8'h20) $display("FAIL b2b_product: prod=%h result=%h required 1000 20", prod, result); else n_pass++;
    repeat (15) @(negedge clk);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; start = 1'b0; a = 8'h0; b = 8'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mult_ctrl

`default_nettype wire
